data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the core's data bus (mem_ctrl/mem_addr/mem_out -> mem_in).
//  Holds a word-addressed SRAM model and returns read data at a fixed latency.
//  Accepts one request per cycle, fully pipelined; there is no back-pressure.
//  Sits between the core's data-cache port and the SoC top; also serves as the
//  bench-side data memory.
// PARAMETERS
//  XLEN        32            data/address width
//  DEPTH       1024          number of XLEN-bit words in the array (power of 2)
//  BASE_ADDR   32'h0000_0000 byte address of word 0
//  RD_LATENCY  2             cycles from request edge to rd_valid (legal 1..4)
// PORTS
//  clk       in   1     clock; all state updates on the rising edge
//  rst       in   1     asynchronous, active-high reset
//  mem_ctrl  in   2     request: 00 idle, 01 read, 10 write, 11 reserved
//  mem_addr  in   XLEN  byte address of the request
//  mem_out   in   XLEN  write data from the core; used when mem_ctrl=10
//  mem_in    out  XLEN  read data to the core
//  rd_valid  out  1     mem_in holds the response for a read issued RD_LATENCY cycles earlier
//  err       out  1     the request issued RD_LATENCY cycles earlier was faulty
// BEHAVIOUR
//  - Reset (async assert, sync release): mem_in=0, rd_valid=0, err=0.
//    In-flight pipeline entries are cleared. Array contents are NOT reset.
//  - A request is accepted on every edge where mem_ctrl!=00. No handshake.
//  - Legal access: mem_addr[1:0]==0 and BASE_ADDR <= mem_addr < BASE_ADDR+4*DEPTH.
//    Word index = (mem_addr-BASE_ADDR)>>2, width $clog2(DEPTH).
//  - Write (10), legal: array[idx] <= mem_out on the accept edge. Full word only.
//    No rd_valid is generated for a write.
//  - Read (01), legal: array[idx] is sampled on the accept edge into stage 1 and
//    shifted through RD_LATENCY-1 further stages.
//    rd_valid=1 and mem_in=data exactly RD_LATENCY cycles after the accept edge.
//  - Read-after-write: a write at edge N followed by a read of the same address
//    at edge N+1 returns the new data. No same-cycle conflict is possible.
//  - Faulty request: misaligned, out of range, or mem_ctrl=11.
//    A faulty write does not modify the array.
//    A faulty read still produces rd_valid, with mem_in=0.
//    err pulses for 1 cycle RD_LATENCY cycles after any faulty request.
//    For reads, err coincides with rd_valid. For writes and 11, rd_valid stays 0.
//  - The pipeline carries {valid, err, data} per stage and shifts every cycle.
//    Back-to-back reads give back-to-back rd_valid pulses in issue order.
//  - When rd_valid=0, mem_in holds its last driven value (0 after reset).
//  - Reset mid-operation: requests accepted before reset never produce rd_valid or err.
//    Requests on the first edge after release are served normally.
// TESTING
//  1. Write 0xDEADBEEF to 0x10 at edge 0, read 0x10 at edge 1
//     -> rd_valid=1, mem_in=0xDEADBEEF, err=0 after edge 3.
//  2. Reads of 0x0, 0x4, 0x8 on edges 0..2 (preloaded 1,2,3)
//     -> rd_valid high after edges 2..4 with mem_in=1,2,3; low after edge 5.
//  3. Read 0x13 (misaligned) -> rd_valid=1, err=1, mem_in=0 after 2 cycles.
//     Write to BASE+4*DEPTH -> err only; word DEPTH-1 is unchanged on readback.
//  4. mem_ctrl=11 at edge 0 -> err=1, rd_valid=0 after edge 2; array unchanged.
//  5. Reads at edges 0 and 1, rst pulsed between edges 1 and 2
//     -> outputs 0 immediately; no rd_valid/err afterwards.
//     A read at the first post-reset edge returns correct data.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed SRAM model on the core data bus. Reads return after a fixed,
// fully pipelined latency; faulty requests are flagged on the err output.
module data_mem_responder #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR  = '0,
  parameter int              RD_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mem_ctrl,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_out,
  output logic [XLEN-1:0] mem_in,
  output logic            rd_valid,
  output logic            err
);

  typedef enum logic [1:0] {
    CtrlIdle  = 2'b00,
    CtrlRead  = 2'b01,
    CtrlWrite = 2'b10,
    CtrlRsvd  = 2'b11
  } ctrl_e;

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [XLEN:0] SPAN = (XLEN+1)'(DEPTH) << 2;

  logic [XLEN-1:0] memArray [DEPTH];

  logic [XLEN-1:0] offset;
  logic            aligned;
  logic            inRange;
  logic            legal;
  logic            isRead;
  logic            isWrite;
  logic            isRsvd;
  logic [AW-1:0]   wordIdx;

  logic            stage0Valid_d;
  logic            stage0Err_d;
  logic [XLEN-1:0] stage0Data_d;
  logic [XLEN-1:0] memIn_d;

  logic            pipeValid_q [RD_LATENCY];
  logic            pipeErr_q   [RD_LATENCY];
  logic [XLEN-1:0] pipeData_q  [RD_LATENCY];
  logic            rdValid_q;
  logic            err_q;
  logic [XLEN-1:0] memIn_q;

  // The range test widens by one bit so BASE_ADDR + 4*DEPTH cannot wrap.
  always_comb begin
    offset  = mem_addr - BASE_ADDR;
    aligned = (mem_addr[1:0] == 2'b00);
    inRange = (mem_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    legal   = aligned && inRange;
    wordIdx = offset[AW+1:2];
    isRead  = (mem_ctrl == CtrlRead);
    isWrite = (mem_ctrl == CtrlWrite);
    isRsvd  = (mem_ctrl == CtrlRsvd);
  end

  always_comb begin
    stage0Valid_d = isRead;
    stage0Err_d   = isRsvd || ((isRead || isWrite) && !legal);
    stage0Data_d  = '0;
    if (isRead && legal) begin
      stage0Data_d = memArray[wordIdx];
    end
  end

  always_comb begin
    memIn_d = memIn_q;
    if (pipeValid_q[RD_LATENCY-1]) begin
      memIn_d = pipeData_q[RD_LATENCY-1];
    end
  end

  // Array contents survive reset, so the write port has no reset branch.
  always_ff @(posedge clk) begin
    if (isWrite && legal) begin
      memArray[wordIdx] <= mem_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipeValid_q[i] <= 1'b0;
        pipeErr_q[i]   <= 1'b0;
        pipeData_q[i]  <= '0;
      end
      rdValid_q <= 1'b0;
      err_q     <= 1'b0;
      memIn_q   <= '0;
    end else begin
      pipeValid_q[0] <= stage0Valid_d;
      pipeErr_q[0]   <= stage0Err_d;
      pipeData_q[0]  <= stage0Data_d;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        pipeErr_q[i]   <= pipeErr_q[i-1];
        pipeData_q[i]  <= pipeData_q[i-1];
      end
      rdValid_q <= pipeValid_q[RD_LATENCY-1];
      err_q     <= pipeErr_q[RD_LATENCY-1];
      memIn_q   <= memIn_d;
    end
  end

  assign mem_in   = memIn_q;
  assign rd_valid = rdValid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a table of directed vectors, a mid-operation
// reset sequence, then randomized traffic against a queue-based memory model.
module tb_data_mem_responder;

  localparam int          XLEN       = 32;
  localparam int          DEPTH      = 1024;
  localparam logic [31:0] BASE_ADDR  = 32'h0;
  localparam int          RD_LATENCY = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      mem_ctrl;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_out;
  logic [XLEN-1:0] mem_in;
  logic            rd_valid;
  logic            err;

  data_mem_responder #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR),
    .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mem_ctrl(mem_ctrl),
    .mem_addr(mem_addr),
    .mem_out (mem_out),
    .mem_in  (mem_in),
    .rd_valid(rd_valid),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expValid;
    logic        expErr;
    logic [31:0] expData;
    string       name;
  } vector_t;

  // Responses are filed under the absolute edge number they must appear on.
  resp_t       sched [int];
  logic [31:0] modelMem [int];
  vector_t     vecs [$];
  int          edgeNum = 0;
  resp_t       expNow;
  logic [31:0] expMemIn = 32'h0;
  int          checks = 0;
  int          passes = 0;

  task automatic addVec(input logic [1:0] c, input logic [31:0] a, input logic [31:0] w,
                        input logic v, input logic e, input logic [31:0] d, input string n);
    vector_t t;
    t.ctrl = c; t.addr = a; t.wdata = w;
    t.expValid = v; t.expErr = e; t.expData = d; t.name = n;
    vecs.push_back(t);
  endtask

  task automatic modelStep(input logic [1:0] c, input logic [31:0] a, input logic [31:0] w);
    longint off;
    bit     legal;
    int     idx;
    resp_t  r;
    off   = longint'(a) - longint'(BASE_ADDR);
    legal = (a[1:0] == 2'b00) && (off >= 0) && (off < 4 * DEPTH);
    idx   = legal ? int'(off / 4) : 0;
    if (c == 2'b01) begin
      r.valid = 1'b1;
      r.err   = !legal;
      r.data  = legal ? modelMem[idx] : 32'h0;
      sched[edgeNum + RD_LATENCY] = r;
    end else if ((c == 2'b10 && !legal) || c == 2'b11) begin
      r.valid = 1'b0;
      r.err   = 1'b1;
      r.data  = 32'h0;
      sched[edgeNum + RD_LATENCY] = r;
    end else if (c == 2'b10) begin
      modelMem[idx] = w;
    end
    if (sched.exists(edgeNum)) begin
      expNow = sched[edgeNum];
      sched.delete(edgeNum);
    end else begin
      expNow.valid = 1'b0;
      expNow.err   = 1'b0;
      expNow.data  = 32'h0;
    end
    if (expNow.valid) expMemIn = expNow.data;
  endtask

  task automatic applyStimulus(input logic [1:0] c, input logic [31:0] a, input logic [31:0] w);
    mem_ctrl = c;
    mem_addr = a;
    mem_out  = w;
    @(posedge clk);
    edgeNum++;
    modelStep(c, a, w);
    #1;
  endtask

  task automatic checkOutput(input string n, input logic v, input logic e, input logic [31:0] d);
    checks++;
    if (rd_valid === v && err === e && mem_in === d) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got rd_valid=%0b err=%0b mem_in=%h, expected rd_valid=%0b err=%0b mem_in=%h",
               n, rd_valid, err, mem_in, v, e, d);
    end
  endtask

  task automatic checkModel(input string n);
    checkOutput(n, expNow.valid, expNow.err, expMemIn);
  endtask

  function automatic logic [31:0] regionAddr();
    int w;
    w = $urandom_range(0, 31);
    if (w >= 16) w = DEPTH - 32 + w;
    return BASE_ADDR + 32'(w * 4);
  endfunction

  initial begin
    rst      = 1'b1;
    mem_ctrl = 2'b00;
    mem_addr = 32'h0;
    mem_out  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset state", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    // Expectations are the outputs seen just after each vector's own edge.
    addVec(2'b10, 32'h10,  32'hDEADBEEF, 0, 0, 32'h0,        "raw write");
    addVec(2'b01, 32'h10,  32'h0,        0, 0, 32'h0,        "raw read");
    addVec(2'b00, 32'h0,   32'h0,        0, 0, 32'h0,        "raw wait");
    addVec(2'b00, 32'h0,   32'h0,        1, 0, 32'hDEADBEEF, "raw data");
    addVec(2'b00, 32'h0,   32'h0,        0, 0, 32'hDEADBEEF, "raw hold");
    addVec(2'b10, 32'h0,   32'h1,        0, 0, 32'hDEADBEEF, "preload 0");
    addVec(2'b10, 32'h4,   32'h2,        0, 0, 32'hDEADBEEF, "preload 4");
    addVec(2'b10, 32'h8,   32'h3,        0, 0, 32'hDEADBEEF, "preload 8");
    addVec(2'b01, 32'h0,   32'h0,        0, 0, 32'hDEADBEEF, "b2b read 0");
    addVec(2'b01, 32'h4,   32'h0,        0, 0, 32'hDEADBEEF, "b2b read 4");
    addVec(2'b01, 32'h8,   32'h0,        1, 0, 32'h1,        "b2b resp 1");
    addVec(2'b00, 32'h0,   32'h0,        1, 0, 32'h2,        "b2b resp 2");
    addVec(2'b00, 32'h0,   32'h0,        1, 0, 32'h3,        "b2b resp 3");
    addVec(2'b00, 32'h0,   32'h0,        0, 0, 32'h3,        "b2b drop");
    addVec(2'b10, 32'hFFC, 32'h12345678, 0, 0, 32'h3,        "top word write");
    addVec(2'b01, 32'h13,  32'h0,        0, 0, 32'h3,        "misaligned read");
    addVec(2'b10, 32'h1000, 32'hBAD,     0, 0, 32'h3,        "oor write");
    addVec(2'b00, 32'h0,   32'h0,        1, 1, 32'h0,        "misaligned resp");
    addVec(2'b01, 32'hFFC, 32'h0,        0, 1, 32'h0,        "oor write err");
    addVec(2'b00, 32'h0,   32'h0,        0, 0, 32'h0,        "err pulse end");
    addVec(2'b00, 32'h0,   32'h0,        1, 0, 32'h12345678, "top word intact");
    addVec(2'b11, 32'h10,  32'h55,       0, 0, 32'h12345678, "rsvd issue");
    addVec(2'b00, 32'h0,   32'h0,        0, 0, 32'h12345678, "rsvd wait");
    addVec(2'b00, 32'h0,   32'h0,        0, 1, 32'h12345678, "rsvd err");
    addVec(2'b01, 32'h10,  32'h0,        0, 0, 32'h12345678, "rsvd readback");
    addVec(2'b00, 32'h0,   32'h0,        0, 0, 32'h12345678, "rsvd wait2");
    addVec(2'b00, 32'h0,   32'h0,        1, 0, 32'hDEADBEEF, "rsvd unchanged");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ctrl, vecs[i].addr, vecs[i].wdata);
      checkOutput(vecs[i].name, vecs[i].expValid, vecs[i].expErr, vecs[i].expData);
    end

    // Two reads in flight are killed by a reset pulse between edges.
    applyStimulus(2'b01, 32'h0, 32'h0);
    checkOutput("pre-reset read 0", 0, 0, 32'hDEADBEEF);
    applyStimulus(2'b01, 32'h4, 32'h0);
    checkOutput("pre-reset read 4", 0, 0, 32'hDEADBEEF);
    rst = 1'b1;
    sched.delete();
    expMemIn = 32'h0;
    #1;
    checkOutput("mid reset clears", 0, 0, 32'h0);
    #1;
    rst = 1'b0;
    applyStimulus(2'b01, 32'h8, 32'h0);
    checkOutput("killed read 0", 0, 0, 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("killed read 4", 0, 0, 32'h0);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("post-reset read", 1, 0, 32'h3);
    applyStimulus(2'b00, 32'h0, 32'h0);
    checkOutput("post-reset idle", 0, 0, 32'h3);

    // Fill the two address regions the random traffic is allowed to read.
    for (int w = 0; w < 32; w++) begin
      int wi;
      wi = (w < 16) ? w : DEPTH - 32 + w;
      applyStimulus(2'b10, BASE_ADDR + 32'(wi * 4), $urandom);
      checkModel("region fill");
    end

    for (int n = 0; n < 400; n++) begin
      logic [1:0]  c;
      logic [31:0] a;
      int          pick;
      pick = $urandom_range(0, 9);
      if (pick < 2)       c = 2'b00;
      else if (pick < 6)  c = 2'b01;
      else if (pick < 9)  c = 2'b10;
      else                c = 2'b11;
      pick = $urandom_range(0, 9);
      if (pick < 6)       a = regionAddr();
      else if (pick < 8)  a = regionAddr() + 32'($urandom_range(1, 3));
      else if (pick < 9)  a = BASE_ADDR + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
      else                a = 32'hFFFF_FFFC;
      applyStimulus(c, a, $urandom);
      checkModel("random traffic");
    end

    for (int n = 0; n < RD_LATENCY + 1; n++) begin
      applyStimulus(2'b00, 32'h0, 32'h0);
      checkModel("drain");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
